stopwatch_counter: RTL and testbench

//   MM:SS stopwatch time-keeper, fed directly by the clock-enable generator.

---
 rtl/stopwatch_counter.sv | 124 ++++++++++++
 tb/tb_stopwatch_counter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch with BCD digits: 1 Hz counting, 2 Hz field adjust, pause toggle.
// Latency: one cycle from a sampled tick or pulse to registered outputs; no backpressure.
module stopwatch_counter #(
    parameter int MAX_MINUTES = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause_pulse,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       paused,
    output logic       rollover
);

    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } state_t;

    localparam logic [3:0] MAX_MT = 4'(MAX_MINUTES / 10);
    localparam logic [3:0] MAX_MO = 4'(MAX_MINUTES % 10);

    state_t     state_q, state_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic       rollover_q, rollover_d;

    logic       min_at_max, sec_at_max;
    logic [3:0] min_tens_inc, min_ones_inc, sec_tens_inc, sec_ones_inc;

    // Incremented-and-wrapped values of each field; the mode logic picks which to load.
    always_comb begin
        min_at_max = (min_tens_q == MAX_MT) && (min_ones_q == MAX_MO);
        sec_at_max = (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);

        min_tens_inc = min_tens_q;
        min_ones_inc = min_ones_q + 4'd1;
        if (min_at_max) begin
            min_tens_inc = 4'd0;
            min_ones_inc = 4'd0;
        end else if (min_ones_q == 4'd9) begin
            min_tens_inc = min_tens_q + 4'd1;
            min_ones_inc = 4'd0;
        end

        sec_tens_inc = sec_tens_q;
        sec_ones_inc = sec_ones_q + 4'd1;
        if (sec_at_max) begin
            sec_tens_inc = 4'd0;
            sec_ones_inc = 4'd0;
        end else if (sec_ones_q == 4'd9) begin
            sec_tens_inc = sec_tens_q + 4'd1;
            sec_ones_inc = 4'd0;
        end
    end

    // Ticks act under the pre-toggle pause state, so a same-cycle pause still counts once.
    always_comb begin
        state_d    = state_q;
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        rollover_d = 1'b0;

        if (pause_pulse) begin
            state_d = (state_q == RUN) ? PAUSED : RUN;
        end

        if (state_q == RUN) begin
            if (!adj && tick_1hz) begin
                sec_tens_d = sec_tens_inc;
                sec_ones_d = sec_ones_inc;
                if (sec_at_max) begin
                    min_tens_d = min_tens_inc;
                    min_ones_d = min_ones_inc;
                    rollover_d = min_at_max;
                end
            end else if (adj && tick_2hz) begin
                if (sel) begin
                    sec_tens_d = sec_tens_inc;
                    sec_ones_d = sec_ones_inc;
                end else begin
                    min_tens_d = min_tens_inc;
                    min_ones_d = min_ones_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            rollover_q <= rollover_d;
        end
    end

    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
    assign paused   = (state_q == PAUSED);
    assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: directed scenarios plus random traffic, each cycle's
// expected outputs come from an arithmetic minutes/seconds model through a scoreboard queue.
module tb_stopwatch_counter;

    localparam int MAXM = 59;

    logic       clk;
    logic       rst;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       pause_pulse;
    logic       adj;
    logic       sel;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       paused;
    logic       rollover;

    stopwatch_counter #(.MAX_MINUTES(MAXM)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .tick_2hz   (tick_2hz),
        .pause_pulse(pause_pulse),
        .adj        (adj),
        .sel        (sel),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .paused     (paused),
        .rollover   (rollover)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] dig;
        logic        p;
        logic        r;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: elapsed time as plain integers.
    int   m_min = 0;
    int   m_sec = 0;
    bit   m_p   = 1'b0;

    function automatic exp_t pack_exp(int mm, int ss, bit p, bit r);
        exp_t e;
        e.dig = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
        e.p   = p;
        e.r   = r;
        return e;
    endfunction

    function automatic exp_t dut_now();
        exp_t e;
        e.dig = {min_tens, min_ones, sec_tens, sec_ones};
        e.p   = paused;
        e.r   = rollover;
        return e;
    endfunction

    // Scoreboard monitor: one expected entry per clock edge while stimulus runs.
    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = dut_now();
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t: got %h%h:%h%h p=%b r=%b, want %h%h:%h%h p=%b r=%b",
                             $time, a.dig[15:12], a.dig[11:8], a.dig[7:4], a.dig[3:0], a.p, a.r,
                             e.dig[15:12], e.dig[11:8], e.dig[7:4], e.dig[3:0], e.p, e.r);
                end
            end
        end
    end

    task automatic cycle(input bit r_in, input bit t1, input bit t2, input bit pp,
                         input bit a, input bit s);
        bit roll;
        int tot;
        roll = 1'b0;
        @(negedge clk);
        rst         = r_in;
        tick_1hz    = t1;
        tick_2hz    = t2;
        pause_pulse = pp;
        adj         = a;
        sel         = s;
        if (r_in) begin
            m_min = 0;
            m_sec = 0;
            m_p   = 1'b0;
        end else begin
            if (!m_p) begin
                if (!a && t1) begin
                    tot = m_min * 60 + m_sec + 1;
                    if (tot == (MAXM + 1) * 60) begin
                        tot  = 0;
                        roll = 1'b1;
                    end
                    m_min = tot / 60;
                    m_sec = tot % 60;
                end else if (a && t2) begin
                    if (s) m_sec = (m_sec + 1) % 60;
                    else   m_min = (m_min + 1) % (MAXM + 1);
                end
            end
            if (pp) m_p = !m_p;
        end
        sb_q.push_back(pack_exp(m_min, m_sec, m_p, roll));
        @(posedge clk);
        #1;
        rst         = 1'b0;
        tick_1hz    = 1'b0;
        tick_2hz    = 1'b0;
        pause_pulse = 1'b0;
    endtask

    task automatic run_n(input int n, input bit t1, input bit t2, input bit a, input bit s);
        for (int i = 0; i < n; i++) cycle(1'b0, t1, t2, 1'b0, a, s);
    endtask

    task automatic check_now(input string name, input int mm, input int ss,
                             input bit p, input bit r);
        exp_t e;
        exp_t a;
        e = pack_exp(mm, ss, p, r);
        a = dut_now();
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h%h:%h%h p=%b r=%b, want %h%h:%h%h p=%b r=%b", name,
                     a.dig[15:12], a.dig[11:8], a.dig[7:4], a.dig[3:0], a.p, a.r,
                     e.dig[15:12], e.dig[11:8], e.dig[7:4], e.dig[3:0], e.p, e.r);
        end
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Raise rst between edges and look at the outputs before the next edge arrives.
    task automatic async_reset_check();
        #2;
        rst = 1'b1;
        #1;
        check_now("async_reset_immediate", 0, 0, 1'b0, 1'b0);
        m_min = 0;
        m_sec = 0;
        m_p   = 1'b0;
        sb_q.push_back(pack_exp(0, 0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : stimulus
        bit ra;
        bit rs;
        rst         = 1'b1;
        tick_1hz    = 1'b0;
        tick_2hz    = 1'b0;
        pause_pulse = 1'b0;
        adj         = 1'b0;
        sel         = 1'b0;
        #1;
        check_now("reset_before_first_edge", 0, 0, 1'b0, 1'b0);

        // 1: plain counting across a minute boundary
        do_reset();
        run_n(61, 1'b1, 1'b0, 1'b0, 1'b0);
        check_now("t1_61_ticks", 1, 1, 1'b0, 1'b0);

        // 2: adjust both fields to the maximum, then roll over in normal mode
        do_reset();
        run_n(59, 1'b0, 1'b1, 1'b1, 1'b0);
        check_now("t2_adj_minutes", 59, 0, 1'b0, 1'b0);
        run_n(59, 1'b0, 1'b1, 1'b1, 1'b1);
        check_now("t2_adj_seconds", 59, 59, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_now("t2_rollover_pulse", 0, 0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_now("t2_rollover_drop", 0, 0, 1'b0, 1'b0);

        // 3: pause freezes, resume continues
        do_reset();
        run_n(7, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_n(10, 1'b1, 1'b1, 1'b0, 1'b0);
        check_now("t3_paused_frozen", 0, 7, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_n(3, 1'b1, 1'b0, 1'b0, 1'b0);
        check_now("t3_resumed", 0, 10, 1'b0, 1'b0);

        // 4: seconds adjust wraps without carry; 1 Hz ignored in adjust mode
        do_reset();
        run_n(59, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check_now("t4_adj_sec_wrap", 0, 0, 1'b0, 1'b0);
        run_n(5, 1'b1, 1'b0, 1'b1, 1'b1);
        check_now("t4_1hz_ignored_in_adj", 0, 0, 1'b0, 1'b0);

        // 5: tick and pause in the same cycle
        do_reset();
        run_n(5, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_now("t5_tick_with_pause", 0, 6, 1'b1, 1'b0);
        run_n(3, 1'b1, 1'b0, 1'b0, 1'b0);
        check_now("t5_frozen_after", 0, 6, 1'b1, 1'b0);

        // 6: asynchronous reset from 12:34 while paused
        do_reset();
        run_n(12, 1'b0, 1'b1, 1'b1, 1'b0);
        run_n(34, 1'b0, 1'b1, 1'b1, 1'b1);
        check_now("t6_preset_1234", 12, 34, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_now("t6_paused_before_rst", 12, 34, 1'b1, 1'b0);
        async_reset_check();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_now("t6_count_after_rst", 0, 1, 1'b0, 1'b0);

        // Random traffic, including coincident ticks and occasional resets
        ra = 1'b0;
        rs = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(29) == 0) ra = !ra;
            if ($urandom_range(9) == 0)  rs = !rs;
            cycle($urandom_range(599) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                  $urandom_range(19) == 0, ra, rs);
        end

        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
